// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, opcode field position, opcode
// constants and the fetch state encoding.
package fetch_unit_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    // Opcode field lives in the low seven bits of every instruction word.
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE = 7'b0100011;

    // REQ: a request may be offered; WAIT: one fetch is outstanding.
    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding fetch FSM and the
// IF/ID valid/ready register feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [XLEN-1:0]     id_pc,
    output logic [31:0]         id_instr,
    output logic [OPCODE_W-1:0] id_opcode
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state, state_next;
    logic            discard, discard_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            id_valid_next;
    logic [XLEN-1:0] id_pc_next;
    logic [31:0]     id_instr_next;
    logic            accept;
    logic            load;

    assign imem_addr = pc;
    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];

    // Next-state, request and IF/ID update; redirect overrides everything last.
    always_comb begin
        state_next    = state;
        discard_next  = discard;
        pc_next       = pc;
        id_valid_next = id_valid;
        id_pc_next    = id_pc;
        id_instr_next = id_instr;
        imem_req      = 1'b0;
        accept        = 1'b0;
        load          = 1'b0;

        unique case (state)
            REQ: begin
                // Only ask when the IF/ID slot is free or draining this cycle,
                // so the response always has somewhere to land.
                imem_req = !id_valid || id_ready;
                accept   = imem_req && imem_ready;
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next   = REQ;
                    discard_next = 1'b0;
                    load         = !discard && !redirect_valid;
                end
            end
            default: state_next = REQ;
        endcase

        if (id_valid && id_ready) begin
            id_valid_next = 1'b0;
        end

        if (load) begin
            id_valid_next = 1'b1;
            id_pc_next    = pc;
            id_instr_next = imem_rdata;
            pc_next       = pc + STEP;
        end

        if (redirect_valid) begin
            pc_next       = redirect_pc & ALIGN_MASK;
            id_valid_next = 1'b0;
            // The fetch now in flight (or just accepted) belongs to the old
            // path; mark it for dropping unless its data is arriving now.
            if (state == REQ && accept) begin
                discard_next = 1'b1;
            end else if (state == WAIT && !imem_rvalid) begin
                discard_next = 1'b1;
            end
        end
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ;
            discard  <= 1'b0;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= '0;
        end else begin
            state    <= state_next;
            discard  <= discard_next;
            pc       <= pc_next;
            id_valid <= id_valid_next;
            id_pc    <= id_pc_next;
            id_instr <= id_instr_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_instr(id_instr), .id_opcode(id_opcode)
    );

    int vectors = 0;
    int miscompares = 0;

    // Memory environment
    bit          mem_pending;
    int          mem_cnt;
    int          mem_lat = 1;
    logic [31:0] mem_addr_q;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_word = 32'h00A3_0333;
    bit          stale_inject = 1'b0;
    logic [31:0] acc_q[$];

    // Reference model: next fetch PC, whether a fetch is in flight and whether
    // it belongs to a flushed path, and what decode should currently see.
    logic [31:0] m_pc, m_id_pc, m_instr;
    bit          m_out, m_drop, m_valid;
    logic        exp_req, obs_req;
    logic [31:0] exp_addr, obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_fixed) return fixed_word;
        return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0} ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_instr = 32'h0;
        m_out = 0; m_drop = 0; m_valid = 0;
        mem_pending = 0; mem_cnt = 0;
        acc_q.delete();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        redirect_valid = 0; imem_rvalid = 0; imem_ready = 0; id_ready = 0;
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, sample the request, advance model and memory.
    task automatic tick(input bit rdir, input logic [31:0] rpc, input bit idr, input bit memr);
        logic rv, accept;
        rv = mem_pending && (mem_cnt == 0);
        redirect_valid = rdir; redirect_pc = rpc; id_ready = idr; imem_ready = memr;
        imem_rvalid = rv || stale_inject;
        imem_rdata  = rv ? mem_word(mem_addr_q) : $urandom;
        #1;
        exp_req  = !m_out && (!m_valid || idr);
        exp_addr = m_pc;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        accept   = exp_req && memr;
        if (rdir) begin
            m_pc = {rpc[31:2], 2'b00};
            m_valid = 0;
            if (!m_out) begin
                if (accept) begin m_out = 1; m_drop = 1; end
            end else if (rv) begin
                m_out = 0; m_drop = 0;
            end else begin
                m_drop = 1;
            end
        end else begin
            if (m_valid && idr) m_valid = 0;
            if (!m_out) begin
                if (accept) begin m_out = 1; m_drop = 0; end
            end else if (rv) begin
                if (!m_drop) begin
                    m_valid = 1; m_id_pc = m_pc; m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4;
                end
                m_out = 0; m_drop = 0;
            end
        end
        if (rv) mem_pending = 0;
        else if (mem_pending) mem_cnt--;
        if (obs_req && memr) begin
            mem_pending = 1; mem_cnt = mem_lat - 1; mem_addr_q = obs_addr;
            acc_q.push_back(obs_addr);
        end
        @(posedge clk); @(negedge clk);
        stale_inject = 0; redirect_valid = 0; imem_rvalid = 0;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
        vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
        vectors++; if (id_instr !== 32'h0) begin miscompares++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
        vectors++; if (id_opcode !== 7'h0) begin miscompares++; $display("FAIL rst_id_opcode: got %h want 0", id_opcode); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential_fetch();
        do_reset();
        use_fixed = 1; mem_lat = 1;
        for (int i = 0; i < 6; i++) begin
            tick(0, 32'h0, 1, 1);
            if (i == 1) begin
                vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL seq_id_valid: got %b want 1", id_valid); end
                vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL seq_id_pc: got %h want 0", id_pc); end
                vectors++; if (id_opcode !== OPC_RTYPE) begin miscompares++; $display("FAIL seq_opcode: got %b want %b", id_opcode, OPC_RTYPE); end
                vectors++; if (id_instr !== 32'h00A3_0333) begin miscompares++; $display("FAIL seq_instr: got %h want 00a30333", id_instr); end
            end
        end
        vectors++;
        if (acc_q.size() !== 3) begin
            miscompares++; $display("FAIL seq_req_count: got %0d want 3", acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (acc_q[i] !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_addr%0d: got %h want %h", i, acc_q[i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        use_fixed = 1; mem_lat = 1;
        tick(0, 32'h0, 0, 1);
        tick(0, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 32'h0, 0, 1);
            vectors++; if (obs_req !== 1'b0) begin miscompares++; $display("FAIL bp_req%0d: got %b want 0", i, obs_req); end
            vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h00A3_0333) begin
                miscompares++; $display("FAIL bp_hold%0d: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00a30333", i, id_valid, id_pc, id_instr);
            end
        end
        tick(0, 32'h0, 1, 1);
        vectors++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin
            miscompares++; $display("FAIL bp_release: got req=%b addr=%h want req=1 addr=4", obs_req, obs_addr);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        use_fixed = 0; mem_lat = 4;
        tick(0, 32'h0, 1, 1);
        tick(1, 32'h0000_0103, 1, 1);
        vectors++; if (obs_req !== 1'b0) begin miscompares++; $display("FAIL rdw_req: got %b want 0", obs_req); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 32'h0, 1, 1);
            vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rdw_drop%0d: got id_valid %b want 0", i, id_valid); end
        end
        tick(0, 32'h0, 1, 0);
        vectors++; if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0100) begin
            miscompares++; $display("FAIL rdw_target: got req=%b addr=%h want req=1 addr=00000100", obs_req, obs_addr);
        end
    endtask

    task automatic test_redirect_with_rvalid();
        do_reset();
        use_fixed = 0; mem_lat = 2;
        tick(0, 32'h0, 1, 1);
        tick(0, 32'h0, 1, 1);
        tick(1, 32'h0000_0200, 1, 1);
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rdv_flush: got id_valid %b want 0", id_valid); end
        tick(0, 32'h0, 1, 1);
        vectors++; if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0200) begin
            miscompares++; $display("FAIL rdv_target: got req=%b addr=%h want req=1 addr=00000200", obs_req, obs_addr);
        end
        tick(0, 32'h0, 0, 1);
        tick(0, 32'h0, 0, 1);
        vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0200 || id_instr !== mem_word(32'h0000_0200)) begin
            miscompares++; $display("FAIL rdv_no_discard: got v=%b pc=%h instr=%h want v=1 pc=00000200 instr=%h",
                                    id_valid, id_pc, id_instr, mem_word(32'h0000_0200));
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        use_fixed = 0; mem_lat = 1;
        tick(1, 32'hFFFF_FFFE, 1, 0);
        tick(0, 32'h0, 1, 1);
        vectors++; if (obs_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h want fffffffc", obs_addr); end
        tick(0, 32'h0, 1, 1);
        vectors++; if (id_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_id_pc: got %h want fffffffc", id_pc); end
        tick(0, 32'h0, 1, 1);
        vectors++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            miscompares++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", obs_req, obs_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        use_fixed = 0; mem_lat = 1;
        tick(1, 32'h0000_0040, 1, 0);
        tick(0, 32'h0, 1, 1);
        tick(0, 32'h0, 0, 1);
        vectors++; if (id_pc !== 32'h0000_0040) begin miscompares++; $display("FAIL rmw_pre_pc: got %h want 00000040", id_pc); end
        mem_lat = 3;
        tick(0, 32'h0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_opcode !== 7'h0) begin
            miscompares++; $display("FAIL rmw_zero: got v=%b pc=%h instr=%h op=%h want all 0", id_valid, id_pc, id_instr, id_opcode);
        end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmw_addr: got %h want 0", imem_addr); end
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        stale_inject = 1;
        tick(0, 32'h0, 1, 0);
        vectors++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            miscompares++; $display("FAIL rmw_first_req: got req=%b addr=%h want req=1 addr=0", obs_req, obs_addr);
        end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rmw_stale: got id_valid %b want 0", id_valid); end
    endtask

    task automatic test_random();
        bit rdir;
        logic [31:0] rpc;
        do_reset();
        use_fixed = 0;
        for (int i = 0; i < 400; i++) begin
            mem_lat = $urandom_range(1, 3);
            rdir = ($urandom_range(0, 99) < 8);
            rpc  = $urandom;
            stale_inject = !mem_pending && ($urandom_range(0, 9) == 0);
            tick(rdir, rpc, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7));
            vectors++; if (obs_req !== exp_req) begin miscompares++; $display("FAIL rnd_req@%0d: got %b want %b", i, obs_req, exp_req); end
            if (exp_req) begin
                vectors++; if (obs_addr !== exp_addr) begin miscompares++; $display("FAIL rnd_addr@%0d: got %h want %h", i, obs_addr, exp_addr); end
            end
            vectors++; if (id_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b want %b", i, id_valid, m_valid); end
            vectors++; if (id_pc !== m_id_pc) begin miscompares++; $display("FAIL rnd_pc@%0d: got %h want %h", i, id_pc, m_id_pc); end
            vectors++; if (id_instr !== m_instr) begin miscompares++; $display("FAIL rnd_instr@%0d: got %h want %h", i, id_instr, m_instr); end
            vectors++; if (id_opcode !== m_instr[6:0]) begin miscompares++; $display("FAIL rnd_opcode@%0d: got %h want %h", i, id_opcode, m_instr[6:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_with_rvalid();
        test_pc_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
